// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE/RUN/HALTED control with multi-cycle
// instructions, stall, branch redirect and saturating cycle/retire counters.
module fetch_sequencer #(
    parameter int unsigned     PW         = 10,
    parameter int unsigned     IW         = 9,
    parameter int unsigned     CW         = 16,
    parameter int unsigned     CPI        = 1,
    parameter logic [PW-1:0]   START_ADDR = '0,
    parameter logic [IW-1:0]   HALT_INSTR = '1
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          start,
    input  logic          stall,
    input  logic [IW-1:0] instruction,
    input  logic          branch_en,
    input  logic          branch_rel,
    input  logic [PW-1:0] branch_target,
    output logic [PW-1:0] PC,
    output logic          retire,
    output logic          halt,
    output logic [CW-1:0] cycle_ct,
    output logic [CW-1:0] instr_ct
);

    localparam int unsigned PHW = (CPI > 1) ? $clog2(CPI) : 1;
    localparam logic [PHW-1:0] LAST_PH = PHW'(CPI - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t         state_q;
    logic [PW-1:0]  pc_q;
    logic [PW-1:0]  pc_d;
    logic [PHW-1:0] phase_q;
    logic [CW-1:0]  cyc_q;
    logic [CW-1:0]  cyc_d;
    logic [CW-1:0]  ins_q;
    logic [CW-1:0]  ins_d;
    logic           halt_q;
    logic           is_halt;

    assign retire  = (state_q == RUN) && !stall && (phase_q == LAST_PH);
    assign is_halt = (instruction == HALT_INSTR);

    always_comb begin
        pc_d  = pc_q + PW'(1);
        cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + CW'(1);
        ins_d = (ins_q == '1) ? ins_q : ins_q + CW'(1);
        // Relative offsets wrap naturally since target and PC share a width.
        if (branch_en) begin
            pc_d = branch_rel ? pc_q + branch_target : branch_target;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
            phase_q <= '0;
            cyc_q   <= '0;
            ins_q   <= '0;
            halt_q  <= 1'b0;
        end else if (start) begin
            state_q <= RUN;
            pc_q    <= START_ADDR;
            phase_q <= '0;
            cyc_q   <= '0;
            ins_q   <= '0;
            halt_q  <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    cyc_q <= cyc_d;
                    if (retire) begin
                        phase_q <= '0;
                        ins_q   <= ins_d;
                        if (is_halt) begin
                            state_q <= HALTED;
                            halt_q  <= 1'b1;
                        end else begin
                            pc_q <= pc_d;
                        end
                    end else if (!stall) begin
                        phase_q <= phase_q + PHW'(1);
                    end
                end
                HALTED: halt_q <= 1'b1;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PC       = pc_q;
    assign halt     = halt_q;
    assign cycle_ct = cyc_q;
    assign instr_ct = ins_q;

endmodule
